// File: rtl/aib_train_pkg.sv
// Shared types and sizing helpers for the AIB receive-tap link trainer.
package aib_train_pkg;

    // Width of the optional per-channel error counters
    localparam int unsigned ErrCntW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CLEAR,
        ST_DWELL,
        ST_EVAL,
        ST_CENTER,
        ST_DONE
    } train_state_e;

    // Bits needed by a counter that runs 0 .. max_count-1
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/aib_eye_window_tracker.sv
// Per-channel eye tracker: follows the current run of passing taps and keeps
// the longest one seen; ties keep the earlier (lower-start) window.
module aib_eye_window_tracker
    import aib_train_pkg::*;
#(
    parameter int unsigned TapW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_upd,
    input  logic            i_pass,
    input  logic [TapW-1:0] i_tap,
    output logic [TapW-1:0] o_best_start,
    output logic [TapW:0]   o_best_len,
    output logic            o_pass
);

    logic [TapW-1:0] run_start;
    logic [TapW:0]   run_len;
    logic [TapW-1:0] run_start_nxt;
    logic [TapW:0]   run_len_nxt;

    // Run that results if the current tap passes
    always_comb begin
        run_len_nxt   = run_len + (TapW+1)'(1);
        run_start_nxt = (run_len == '0) ? i_tap : run_start;
    end

    // Run/best bookkeeping; comparing on every pass closes a run open at the last tap
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            run_start    <= '0;
            run_len      <= '0;
            o_best_start <= '0;
            o_best_len   <= '0;
            o_pass       <= 1'b0;
        end else if (i_upd) begin
            if (i_pass) begin
                run_start <= run_start_nxt;
                run_len   <= run_len_nxt;
                o_pass    <= 1'b1;
                if (run_len_nxt > o_best_len) begin
                    o_best_start <= run_start_nxt;
                    o_best_len   <= run_len_nxt;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule

// File: rtl/aib_link_trainer.sv
// AIB receive delay-tap trainer: sweeps taps 0..TapMax on all channels,
// observes the pattern checker at each tap and centres each channel in its
// widest passing window. Define AIB_TRAIN_ERRCNT_EN to add o_err_cnt.
module aib_link_trainer
    import aib_train_pkg::*;
#(
    parameter int unsigned NumChn       = 2,
    parameter int unsigned TapW         = 8,
    parameter int unsigned TapMax       = 255,
    parameter int unsigned SettleCycles = 16,
    parameter int unsigned DwellCycles  = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [NumChn-1:0]              i_err,
    input  logic [TapW-1:0]                c_default_tap,
    output logic [NumChn-1:0][TapW-1:0]    o_tap,
    output logic                           o_chk_clr,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [NumChn-1:0]              o_chn_pass,
    output logic [NumChn-1:0][TapW:0]      o_win_len
`ifdef AIB_TRAIN_ERRCNT_EN
    ,
    output logic [NumChn-1:0][ErrCntW-1:0] o_err_cnt
`endif
);

    localparam int unsigned CntMax = (SettleCycles > DwellCycles) ? SettleCycles : DwellCycles;
    localparam int unsigned CntW   = cnt_width(CntMax);

    train_state_e state, state_nxt;
    logic [CntW-1:0]   cnt;
    logic [TapW-1:0]   sweep_tap;
    logic [NumChn-1:0] chn_fail;
    logic              start_acc;
    logic              last_tap;

    logic [NumChn-1:0][TapW-1:0] best_start;
    logic [NumChn-1:0][TapW:0]   best_len;
    logic [NumChn-1:0]           trk_pass;
    logic [NumChn-1:0][TapW-1:0] center_tap;

    // Next-state decode
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        last_tap  = (sweep_tap == TapW'(TapMax));
        case (state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: if (cnt == CntW'(SettleCycles - 1)) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_DWELL;
            ST_DWELL:  if (cnt == CntW'(DwellCycles - 1)) state_nxt = ST_EVAL;
            ST_EVAL:   state_nxt = last_tap ? ST_CENTER : ST_SETTLE;
            ST_CENTER: state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Settle/dwell cycle counter, restarted on every state change
    always_ff @(posedge i_clk) begin
        if (i_rst || (state_nxt != state))                  cnt <= '0;
        else if ((state == ST_SETTLE) || (state == ST_DWELL)) cnt <= cnt + CntW'(1);
    end

    // Sticky per-channel fail flag for the tap under observation
    always_ff @(posedge i_clk) begin
        if (i_rst || (state == ST_CLEAR)) chn_fail <= '0;
        else if (state == ST_DWELL)        chn_fail <= chn_fail | i_err;
    end

    // One eye tracker per channel plus its centre tap
    for (genvar c = 0; c < NumChn; c++) begin : g_chn
        aib_eye_window_tracker #(.TapW(TapW)) u_trk (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_clr        (start_acc),
            .i_upd        (state == ST_EVAL),
            .i_pass       (~chn_fail[c]),
            .i_tap        (sweep_tap),
            .o_best_start (best_start[c]),
            .o_best_len   (best_len[c]),
            .o_pass       (trk_pass[c])
        );
        assign center_tap[c] = best_start[c] + TapW'(best_len[c] >> 1);
    end

    // Registered outputs and sweep tap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sweep_tap  <= '0;
            o_tap      <= {NumChn{c_default_tap}};
            o_chk_clr  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_chn_pass <= '0;
            o_win_len  <= '0;
        end else begin
            o_chk_clr <= (state_nxt == ST_CLEAR);
            if (start_acc) begin
                sweep_tap  <= '0;
                o_tap      <= '0;
                o_busy     <= 1'b1;
                o_done     <= 1'b0;
                o_chn_pass <= '0;
                o_win_len  <= '0;
            end else if ((state == ST_EVAL) && !last_tap) begin
                sweep_tap <= sweep_tap + TapW'(1);
                o_tap     <= {NumChn{sweep_tap + TapW'(1)}};
            end else if (state == ST_CENTER) begin
                o_busy     <= 1'b0;
                o_done     <= 1'b1;
                o_chn_pass <= trk_pass;
                o_win_len  <= best_len;
                for (int c = 0; c < NumChn; c++) begin
                    o_tap[c] <= trk_pass[c] ? center_tap[c] : c_default_tap;
                end
            end
        end
    end

`ifdef AIB_TRAIN_ERRCNT_EN
    // Saturating count of erroring dwell cycles across the whole sweep
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < NumChn; c++) begin
            if (i_rst || start_acc) begin
                o_err_cnt[c] <= '0;
            end else if ((state == ST_DWELL) && i_err[c] && (o_err_cnt[c] != {ErrCntW{1'b1}})) begin
                o_err_cnt[c] <= o_err_cnt[c] + ErrCntW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_aib_link_trainer.sv
// Scoreboard bench for aib_link_trainer with a 16-tap sweep and short settle/dwell.
module tb_aib_link_trainer;

    localparam int unsigned NumChn = 2;
    localparam int unsigned TapW   = 4;
    localparam int unsigned TapMax = 15;
    localparam int unsigned Settle = 2;
    localparam int unsigned Dwell  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst;
    logic                        start;
    logic [NumChn-1:0]           err;
    logic [TapW-1:0]             deft;
    logic [NumChn-1:0][TapW-1:0] tap;
    logic                        chk_clr;
    logic                        busy;
    logic                        done;
    logic [NumChn-1:0]           pass;
    logic [NumChn-1:0][TapW:0]   wl;
`ifdef AIB_TRAIN_ERRCNT_EN
    logic [NumChn-1:0][15:0]     ecnt;
`endif

    aib_link_trainer #(
        .NumChn(NumChn), .TapW(TapW), .TapMax(TapMax),
        .SettleCycles(Settle), .DwellCycles(Dwell)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_err         (err),
        .c_default_tap (deft),
        .o_tap         (tap),
        .o_chk_clr     (chk_clr),
        .o_busy        (busy),
        .o_done        (done),
        .o_chn_pass    (pass),
        .o_win_len     (wl)
`ifdef AIB_TRAIN_ERRCNT_EN
        ,
        .o_err_cnt     (ecnt)
`endif
    );

    typedef struct packed {
        logic [1:0]       pass;
        logic [1:0][3:0]  tap;
        logic [1:0][4:0]  len;
        logic [1:0][15:0] ecnt;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] mask [2] = '{16'hFFFF, 16'hFFFF};
    bit          pulse_mode = 1'b0;
    int          dc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic p0, input logic [3:0] t0, input logic [4:0] l0,
                                input logic p1, input logic [3:0] t1, input logic [4:0] l1,
                                input int e0, input int e1);
        exp_t e;
        e.pass    = {p1, p0};
        e.tap[0]  = t0;
        e.tap[1]  = t1;
        e.len[0]  = l0;
        e.len[1]  = l1;
        e.ecnt[0] = 16'(e0);
        e.ecnt[1] = 16'(e1);
        return e;
    endfunction

    function automatic int ferr(input logic [15:0] m);
        return 4 * (16 - $countones(m));
    endfunction

    // Pattern-checker model: dc=1..4 are the dwell cycles after each clear pulse
    initial begin
        err = '0;
        forever begin
            @(negedge clk);
            if (chk_clr) dc = 0;
            else         dc = dc + 1;
            for (int c = 0; c < 2; c++) begin
                if (pulse_mode) err[c] = (c == 0) && (tap[0] == 4'd10) && (dc == 4);
                else            err[c] = !mask[c][tap[c]];
            end
        end
    end

    // Monitor: compare against the scoreboard whenever a result is presented
    initial begin
        bit   dq;
        exp_t e;
        dq = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !dq) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    for (int c = 0; c < 2; c++) begin
                        chk($sformatf("ch%0d_pass", c), int'(pass[c]), int'(e.pass[c]));
                        chk($sformatf("ch%0d_tap", c), int'(tap[c]), int'(e.tap[c]));
                        chk($sformatf("ch%0d_win_len", c), int'(wl[c]), int'(e.len[c]));
`ifdef AIB_TRAIN_ERRCNT_EN
                        chk($sformatf("ch%0d_err_cnt", c), int'(ecnt[c]), int'(e.ecnt[c]));
`endif
                    end
                end
            end
            dq = done;
        end
    end

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done"}, int'(done), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic launch(input logic [15:0] m0, input logic [15:0] m1, input logic [3:0] dt, input bit pm);
        @(negedge clk);
        mask[0]    = m0;
        mask[1]    = m1;
        deft       = dt;
        pulse_mode = pm;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_dwell(input logic [3:0] t, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (!ok && k < 1000) begin
            @(negedge clk);
            k++;
            ok = busy && (tap[0] == t) && (dc >= 2) && (dc <= 3);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_chk_clr"}, int'(chk_clr), 0);
        chk({nm, "_pass"}, int'(pass), 0);
        chk({nm, "_wl0"}, int'(wl[0]), 0);
        chk({nm, "_wl1"}, int'(wl[1]), 0);
        chk({nm, "_tap0"}, int'(tap[0]), int'(deft));
        chk({nm, "_tap1"}, int'(tap[1]), int'(deft));
`ifdef AIB_TRAIN_ERRCNT_EN
        chk({nm, "_ecnt0"}, int'(ecnt[0]), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst   = 1'b1;
        start = 1'b0;
        deft  = 4'd5;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // Full eye on both channels, plus a start pulse mid-sweep that must be ignored
        sb.push_back(mk(1'b1, 4'd8, 5'd16, 1'b1, 4'd8, 5'd16, 0, 0));
        launch(16'hFFFF, 16'hFFFF, 4'd5, 1'b0);
        wait_dwell(4'd5, ok);
        chk("busy_wait", int'(ok), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_start_tap", int'(tap[0]), 5);
        chk("ign_start_busy", int'(busy), 1);
        wait_done("all_pass");

        // ch0 windows 3-9 and 12-14; ch1 window 0-5
        sb.push_back(mk(1'b1, 4'd6, 5'd7, 1'b1, 4'd3, 5'd6, ferr(16'h73F8), ferr(16'h003F)));
        launch(16'h73F8, 16'h003F, 4'd5, 1'b0);
        wait_done("two_win");

        // ch1 never passes: default tap applied
        sb.push_back(mk(1'b1, 4'd8, 5'd16, 1'b0, 4'd5, 5'd0, 0, ferr(16'h0000)));
        launch(16'hFFFF, 16'h0000, 4'd5, 1'b0);
        wait_done("no_pass");

        // Equal windows pick the lower one; run at TapMax closes there without wrapping
        sb.push_back(mk(1'b1, 4'd3, 5'd3, 1'b1, 4'd14, 5'd3, ferr(16'h1C1C), ferr(16'hE003)));
        launch(16'h1C1C, 16'hE003, 4'd9, 1'b0);
        wait_done("tie_edge");

        // Reset in the dwell of tap 7 aborts the sweep
        launch(16'hFFFF, 16'hFFFF, 4'd5, 1'b0);
        wait_dwell(4'd7, ok);
        chk("abort_wait", int'(ok), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("abort");
        rst = 1'b0;

        // Single error in the last dwell cycle of tap 10 fails that tap
        sb.push_back(mk(1'b1, 4'd5, 5'd10, 1'b1, 4'd8, 5'd16, 1, 0));
        launch(16'hFFFF, 16'hFFFF, 4'd5, 1'b1);
        wait_done("last_pulse");

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aib_link_trainer.md
AIB_LINK_TRAINER -- requirements
Module: aib_link_trainer

Interface
REQ-001 SHALL have parameter NumChn, default 2, number of AIB channels trained in parallel.
REQ-002 SHALL have parameter TapW, default 8, width of the receive delay-tap code.
REQ-003 SHALL have parameter TapMax, default 255, highest tap swept; must not exceed 2**TapW-1.
REQ-004 SHALL have parameter SettleCycles, default 16, cycles waited after each tap change.
REQ-005 SHALL have parameter DwellCycles, default 1024, error-observation cycles per tap.
REQ-006 SHALL have port i_clk  input  1  training clock (aib_clk domain); the block uses one clock, reset is synchronous and active-high.
REQ-007 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port i_start  input  1  single-cycle training request.
REQ-009 SHALL have port i_err  input  NumChn  per-channel error flag from the pattern checker, sampled during dwell.
REQ-010 SHALL have port c_default_tap  input  TapW  tap applied to a channel with no passing tap.
REQ-011 SHALL have port o_tap  output  NumChn x TapW  receive delay tap per channel.
REQ-012 SHALL have port o_chk_clr  output  1  checker clear pulse.
REQ-013 SHALL have port o_busy  output  1  training in progress.
REQ-014 SHALL have port o_done  output  1  training complete; held until the next accepted i_start.
REQ-015 SHALL have port o_chn_pass  output  NumChn  channel found at least one passing tap.
REQ-016 SHALL have port o_win_len  output  NumChn x (TapW+1)  length of the chosen passing window.

Function
REQ-017 SHALL implement FSM IDLE, SETTLE, CLEAR, DWELL, EVAL, CENTER, DONE.
REQ-018 SHALL accept i_start only in IDLE or DONE, move to SETTLE next cycle with sweep tap 0 on all channels, clear o_done and assert o_busy; i_start in other states is ignored.
REQ-019 SHALL count SettleCycles in SETTLE, then spend exactly one cycle in CLEAR with o_chk_clr=1.
REQ-020 SHALL spend exactly DwellCycles cycles in DWELL; a channel fails the current tap if i_err is 1 in any of those cycles.
REQ-021 SHALL, in EVAL, update per-channel window tracking; if tap<TapMax, increment tap and return to SETTLE, else go to CENTER.
REQ-022 SHALL track, per channel, the longest contiguous run of passing taps; on equal length the lowest-start window wins.
REQ-023 SHALL close a run still open at TapMax as ending at TapMax (no wrap-around to tap 0).
REQ-024 SHALL, in CENTER (one cycle), set o_tap = start + floor(len/2) for passing channels and c_default_tap for channels with no passing tap, then go to DONE.
REQ-025 SHALL drive o_tap to the sweep tap on every channel while o_busy=1.
REQ-026 SHALL deassert o_busy and assert o_done and o_chn_pass/o_win_len valid on the cycle DONE is entered.

Reset
REQ-027 SHALL, while i_rst=1, force state IDLE, o_tap all c_default_tap, o_chk_clr=0, o_busy=0, o_done=0, o_chn_pass=0, o_win_len=0, all counters 0.
REQ-028 SHALL abort training on i_rst mid-sweep with no partial result retained.

Configuration
REQ-029 SHALL, with AIB_TRAIN_ERRCNT_EN defined, add output o_err_cnt (NumChn x 16) counting DWELL cycles with i_err=1 over the whole sweep, saturating at 16'hFFFF, cleared on accepted i_start and reset.
REQ-030 SHALL, without AIB_TRAIN_ERRCNT_EN, omit o_err_cnt and its counters entirely.

Structure
REQ-031 SHALL place the FSM state enum and the counter-width helper constant in package aib_train_pkg.
REQ-032 SHALL instantiate one sub-module aib_eye_window_tracker per channel (run start/length, best start/length, pass flag).

Verification
REQ-033 SHALL cover: TapMax=15, i_err=0 always -> win_len 16, o_tap 8, chn_pass 1.
REQ-034 SHALL cover: ch0 passes taps 3-9 and 12-14 -> ch0 o_tap 6, win_len 7; ch1 independent.
REQ-035 SHALL cover: i_err=1 always on ch1, c_default_tap 5 -> ch1 chn_pass 0, o_tap 5, win_len 0.
REQ-036 SHALL cover: windows 2-4 and 10-12 equal length -> o_tap 3; passing run 13-15 at TapMax -> closed at 15.
REQ-037 SHALL cover: i_rst asserted in DWELL of tap 7 -> next cycle all outputs at reset values; i_start during busy ignored.
REQ-038 SHALL cover: single i_err pulse in last DWELL cycle of a tap -> that tap fails; with AIB_TRAIN_ERRCNT_EN o_err_cnt=1.
